// File: rtl/poly_controller.sv
// Sequencer for the 4-stage ring polynomial datapath: loads X/N, runs deg ring
// advances, then presents the result (or a rejection) until the consumer acks.
module poly_controller #(
    parameter int N_WIDTH   = 3,
    parameter int CNT_WIDTH = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [N_WIDTH-1:0] i_n_input,
    input  logic               i_error,
    input  logic               i_overflow,
    input  logic               i_ack,
    output logic               o_load_x,
    output logic               o_load_n,
    output logic               o_ready,
    output logic               o_load_registers,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err_flag,
    output logic               o_ovf_flag
);

    // state  | meaning
    // S_IDLE | waiting for start; load_x/load_n follow start combinationally
    // S_LOAD | datapath X/N now valid; check error input and degree
    // S_CALC | deg ring-advance cycles, ready only on the first
    // S_DONE | result presented with valid/done until ack
    // S_ERR  | request rejected, done/err_flag until ack
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [N_WIDTH-1:0]   r_deg;
    logic                 r_ovf;
    logic                 r_err;
    logic [CNT_WIDTH-1:0] w_deg_m1;
    logic                 w_last;
    logic                 w_reject;

    // deg is never zero in CALC, so the decrement cannot wrap there
    assign w_deg_m1 = CNT_WIDTH'(r_deg) - CNT_WIDTH'(1);
    assign w_last   = (r_cnt == w_deg_m1);
    assign w_reject = i_error || (r_deg == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        o_load_x         = 1'b0;
        o_load_n         = 1'b0;
        o_ready          = 1'b0;
        o_load_registers = 1'b0;
        o_valid          = 1'b0;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    o_load_x    = 1'b1;
                    o_load_n    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = w_reject ? S_ERR : S_CALC;
            end
            S_CALC: begin
                o_load_registers = 1'b1;
                o_ready          = (r_cnt == '0);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                o_done  = 1'b1;
                if (i_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                o_done = 1'b1;
                if (i_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_deg <= '0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_deg <= i_n_input;
                        r_ovf <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_reject) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    r_ovf <= r_ovf | i_overflow;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_err_flag = r_err;
    assign o_ovf_flag = r_ovf;

endmodule

// File: tb/tb_poly_controller.sv
// Scoreboard bench for poly_controller: expected per-request results are queued
// at start and compared when done rises.
module tb_poly_controller;

    logic       clk;
    logic       i_reset;
    logic       i_start;
    logic [2:0] i_n_input;
    logic       i_error;
    logic       i_overflow;
    logic       i_ack;
    logic       o_load_x, o_load_n, o_ready, o_load_registers, o_valid;
    logic       o_busy, o_done, o_err_flag, o_ovf_flag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   lat;
        logic err;
        logic ovf;
        int   nld;
        int   nrdy;
    } exp_t;

    exp_t sb[$];

    poly_controller #(.N_WIDTH(3), .CNT_WIDTH(3)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_start          (i_start),
        .i_n_input        (i_n_input),
        .i_error          (i_error),
        .i_overflow       (i_overflow),
        .i_ack            (i_ack),
        .o_load_x         (o_load_x),
        .o_load_n         (o_load_n),
        .o_ready          (o_ready),
        .o_load_registers (o_load_registers),
        .o_valid          (o_valid),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err_flag       (o_err_flag),
        .o_ovf_flag       (o_ovf_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {o_load_x, o_load_n, o_ready, o_load_registers, o_valid,
                o_busy, o_done, o_err_flag, o_ovf_flag};
    endfunction

    task automatic run_op(input int n, input bit err_in, input int ovfk, input int hold,
                          input bit ack_start, input bit start_calc);
        exp_t e;
        exp_t g;
        int   c;
        int   nld;
        int   nrdy;
        int   rdy_at;
        int   nlx;
        bit   seen;
        e.err  = (n == 0) || err_in;
        e.lat  = e.err ? 2 : 2 + n;
        e.nld  = e.err ? 0 : n;
        e.nrdy = e.err ? 0 : 1;
        e.ovf  = !e.err && ovfk >= 0 && ovfk < n;
        sb.push_back(e);

        @(negedge clk);
        i_start   = 1'b1;
        i_n_input = n[2:0];
        #1;
        check_eq("start_load_xn", {30'd0, o_load_x, o_load_n}, 32'd3);
        check_eq("start_excl", {29'd0, o_ready, o_load_registers, o_valid}, 32'd0);

        c = 0; nld = 0; nrdy = 0; rdy_at = 0; nlx = 0; seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            i_start    = start_calc && (c == 3);
            i_error    = (c == 1) ? err_in : 1'b0;
            i_overflow = (ovfk >= 0) && (c == 2 + ovfk);
            #1;
            if (o_ready) begin
                nrdy++;
                rdy_at = c;
            end
            if (o_load_registers) nld++;
            if (o_load_x || o_load_n) nlx++;
            if (o_done) seen = 1'b1;
        end
        i_start = 1'b0; i_error = 1'b0; i_overflow = 1'b0;

        g = sb.pop_front();
        if (!seen) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            i_reset = 1'b1;
            @(negedge clk);
            i_reset = 1'b0;
            return;
        end
        check_eq("latency", c, g.lat);
        check_eq("err_flag", {31'd0, o_err_flag}, {31'd0, g.err});
        check_eq("ovf_flag", {31'd0, o_ovf_flag}, {31'd0, g.ovf});
        check_eq("valid", {31'd0, o_valid}, {31'd0, ~g.err});
        check_eq("ldreg_cycles", nld, g.nld);
        check_eq("ready_cycles", nrdy, g.nrdy);
        if (g.nrdy > 0) check_eq("ready_pos", rdy_at, 2);
        check_eq("load_x_while_busy", nlx, 0);

        repeat (hold) begin
            @(negedge clk);
            #1;
            check_eq("hold", {29'd0, o_done, o_valid, o_load_registers},
                     {29'd0, 1'b1, ~g.err, 1'b0});
        end

        i_ack = 1'b1;
        if (ack_start) i_start = 1'b1;
        #1;
        if (ack_start) check_eq("ackstart_no_load_x", {31'd0, o_load_x}, 32'd0);
        @(negedge clk);
        i_ack = 1'b0;
        #1;
        check_eq("after_ack", {27'd0, o_busy, o_done, o_valid, o_load_registers, o_ready}, 32'd0);
        check_eq("flag_hold_idle", {31'd0, o_err_flag}, {31'd0, g.err});
        if (ack_start) begin
            check_eq("ackstart_idle_load_x", {31'd0, o_load_x}, 32'd1);
            i_start = 1'b0;
        end
    endtask

    task automatic reset_mid_calc();
        @(negedge clk);
        i_start   = 1'b1;
        i_n_input = 3'd5;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("calc2_ldreg", {31'd0, o_load_registers}, 32'd1);
        i_reset = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_reset_outs", {23'd0, outs()}, 32'd0);
        i_reset = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_reset_idle", {23'd0, outs()}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_n_input = 3'd0;
        i_error = 1'b0; i_overflow = 1'b0; i_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs", {23'd0, outs()}, 32'd0);
        i_reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            check_eq("idle_outs", {23'd0, outs()}, 32'd0);
        end

        run_op(3, 1'b0, -1, 5, 1'b0, 1'b0);
        run_op(7, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(0, 1'b0, -1, 2, 1'b0, 1'b0);
        run_op(4, 1'b1, -1, 1, 1'b0, 1'b0);
        run_op(5, 1'b0, 2, 2, 1'b0, 1'b0);
        run_op(4, 1'b0, -1, 1, 1'b0, 1'b1);
        run_op(1, 1'b0, -1, 1, 1'b1, 1'b0);
        reset_mid_calc();
        run_op(6, 1'b0, 5, 0, 1'b0, 1'b0);
        run_op(2, 1'b0, 0, 0, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            int n;
            int ovfk;
            n    = $urandom_range(0, 7);
            ovfk = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
            run_op(n, $urandom_range(0, 7) == 0, ovfk, $urandom_range(0, 3),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_controller.md
Name: poly_controller

Overview:
Sequencing FSM for the 4-stage ring polynomial datapath. It accepts a start request and loads X and N into the datapath. It then drives ready and load_registers for exactly N ring-advance cycles and presents the result with valid/done until the consumer acknowledges. It also rejects illegal requests and reports a sticky overflow flag for each computation.

Parameters:
N_WIDTH, 3, width of the degree input and the internal term counter
CNT_WIDTH, 3, width of the term counter (must hold values up to 2^N_WIDTH-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; forces IDLE and clears all registers
start  input  1  request pulse/level, sampled only in IDLE
N_input  input  N_WIDTH  polynomial degree, captured with start
error  input  1  datapath error_detector output, sampled in LOAD
overflow  input  1  datapath OR of stage overflows
ack  input  1  consumer has taken result, sampled in DONE/ERR
load_X  output  1  to datapath X register
load_N  output  1  to datapath N register
ready  output  1  to datapath; selects zero/shifted_x/stage 0 as ring input
load_registers  output  1  to datapath; advances all inter-stage registers
valid  output  1  to datapath; gates result onto its output
busy  output  1  high in every state except IDLE
done  output  1  request finished (result or error), held until ack
err_flag  output  1  request rejected; meaningful when done=1
ovf_flag  output  1  sticky overflow for current computation

Behaviour:
- Reset: state=IDLE, cnt=0, deg=0, ovf_flag=0, err_flag=0. All outputs are 0 in the cycle after reset is sampled. Reset mid-operation aborts immediately with no result.
- States: IDLE, LOAD, CALC, DONE, ERR; registered state, Moore outputs except load_X/load_N.
- IDLE: busy=0. When start=1, assert load_X=load_N=1 combinationally in the same cycle. Capture N_input into deg, clear ovf_flag and err_flag, then go to LOAD. When start=0, stay in IDLE.
- LOAD (1 cycle): datapath X/N registers are now valid. If error=1 or deg==0, set err_flag=1 and go to ERR. Otherwise set cnt=0 and go to CALC.
- CALC: load_registers=1 every cycle. ready=1 only when cnt==0, which injects term 0. Each cycle: cnt<=cnt+1 and ovf_flag<=ovf_flag|overflow. When cnt==deg-1, go to DONE. CALC therefore lasts exactly deg cycles (1..7).
- DONE: valid=1, done=1, load_registers=0, so pipeline registers hold. Stay until ack=1, then go to IDLE.
- ERR: done=1, err_flag=1, valid=0, no datapath loads. Stay until ack=1, then go to IDLE.
- Latency: start sampled at edge t. LOAD occupies cycle t+1, CALC occupies t+2..t+1+deg, and valid/done rise at t+2+deg.
- start outside IDLE is ignored. It is not queued.
- ack outside DONE/ERR is ignored.
- ack and start both high in DONE: return to IDLE; start is not accepted that cycle and must be held or re-asserted.
- ack in the first DONE cycle is legal, giving a 1-cycle done pulse.
- err_flag and ovf_flag hold their values through DONE/ERR and until the next accepted start.
- ready, load_registers and valid are mutually exclusive with load_X/load_N in any cycle.

Test Plan:
- Reset then idle with start=0 for 10 cycles -> all outputs 0, busy=0, state IDLE.
- start with N_input=3, X=0x40, ack=0 -> load_X=load_N=1 at t; ready=1 only at t+2; load_registers=1 at t+2..t+4; valid=done=1 from t+5; holds 5 cycles; ack -> IDLE next cycle, valid=0.
- start with N_input=7 -> exactly 7 load_registers cycles, ready high only on the first; done at t+9; ovf_flag=0 for small X (0x10).
- start with N_input=0 -> ERR at t+2, done=1, err_flag=1, valid=0, zero load_registers cycles. Repeat with error=1 forced in LOAD and N_input=4 -> same response.
- Force overflow=1 for one CALC cycle (N=5) -> ovf_flag=1 in DONE; next start clears it to 0.
- Assert start during CALC -> ignored, cycle count unchanged. Assert reset at 2nd CALC cycle -> next cycle IDLE, all outputs 0. ack+start together in DONE -> IDLE, no load_X that cycle.
